// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: PC register, combinational imem read port and an in-order
// {pc, instr} queue feeding decode. Optional redirect counter under FETCH_REDIRECT_COUNT_EN.
module fetch_queue_unit #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int QUEUE_DEPTH = 4,
   parameter int PC_STEP = 4,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     PCsrc,
   input  logic [ADDRESS_WIDTH-1:0] ImmOp,
   input  logic [ADDRESS_WIDTH-1:0] branch_pc,
   input  logic                     jump_en,
   input  logic [ADDRESS_WIDTH-1:0] jump_target,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0]    imem_data,
   output logic [DATA_WIDTH-1:0]    instr,
   output logic [ADDRESS_WIDTH-1:0] instr_pc,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [31:0]              redirect_count
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);
   localparam logic [ADDRESS_WIDTH-1:0] STEP = ADDRESS_WIDTH'(PC_STEP);
   localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~(STEP - ADDRESS_WIDTH'(1));

   logic [ADDRESS_WIDTH-1:0] pc;
   logic [ADDRESS_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
   logic [DATA_WIDTH-1:0]    q_data [QUEUE_DEPTH];
   logic [PTR_W-1:0]         head;
   logic [PTR_W-1:0]         tail;
   logic [CNT_W-1:0]         count;

   logic                     redirect;
   logic [ADDRESS_WIDTH-1:0] target_raw;
   logic [ADDRESS_WIDTH-1:0] target;
   logic                     enq;
   logic                     deq;

   always_comb begin
      redirect   = jump_en | PCsrc;
      target_raw = jump_en ? jump_target : (branch_pc + ImmOp);
      target     = target_raw & ALIGN_MASK;
      // a full queue never enqueues, even when it dequeues in the same cycle
      enq        = ~redirect & (count < DEPTH_CNT);
      deq        = ~redirect & (count != '0) & instr_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_VECTOR;
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            q_pc[i]   <= '0;
            q_data[i] <= '0;
         end
      end else if (redirect) begin
         pc    <= target;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) begin
            q_pc[tail]   <= pc;
            q_data[tail] <= imem_data;
            tail         <= tail + PTR_W'(1);
            pc           <= pc + STEP;
         end
         if (deq) begin
            head <= head + PTR_W'(1);
         end
         if (enq && !deq) begin
            count <= count + CNT_W'(1);
         end else if (!enq && deq) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // head outputs come only from registered queue state
   assign imem_addr   = pc;
   assign instr       = q_data[head];
   assign instr_pc    = q_pc[head];
   assign instr_valid = (count != '0);

`ifdef FETCH_REDIRECT_COUNT_EN
   logic [31:0] redirect_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_cnt <= '0;
      end else if (redirect) begin
         redirect_cnt <= redirect_cnt + 32'd1;
      end
   end

   assign redirect_count = redirect_cnt;
`else
   assign redirect_count = '0;
`endif

endmodule
